// File: rtl/oam_dma_arbiter.sv
// ---------------------------------------------------------------------------
// oam_dma_arbiter
//
// Sprite-DMA bus master and CPU/DMA bus arbiter. This block sits between the
// CPU core and the system bus decoder. When the CPU writes page P to the
// trigger register, the block takes the bus, copies LEN bytes from
// {P, 8'h00}.. to the fixed destination DST_ADDR, and then returns the bus
// to the CPU. While the copy runs, cpu_rdy_o is held low so that the CPU
// sequencer is frozen.
//
// Ports
//   clk_i         system clock
//   reset_i       synchronous, active-high reset
//   cpu_addr_i    CPU address
//   cpu_dout_i    CPU write data
//   cpu_we_i      CPU write enable
//   cpu_rdy_o     to CPU bus_rdy; low freezes the CPU sequencer
//   bus_addr_o    address driven onto the system bus
//   bus_dout_o    write data driven onto the system bus
//   bus_we_o      write enable driven onto the system bus
//   bus_din_i     read data returned by the system bus
//   dma_active_o  high whenever the DMA engine owns the bus
// ---------------------------------------------------------------------------
module oam_dma_arbiter #(
    parameter logic [15:0] REG_ADDR = 16'h4014,
    parameter logic [15:0] DST_ADDR = 16'h2004,
    parameter int unsigned LEN      = 256
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [15:0] cpu_addr_i,
    input  logic [7:0]  cpu_dout_i,
    input  logic        cpu_we_i,
    output logic        cpu_rdy_o,
    output logic [15:0] bus_addr_o,
    output logic [7:0]  bus_dout_o,
    output logic        bus_we_o,
    input  logic [7:0]  bus_din_i,
    output logic        dma_active_o
);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_e;

    // idx is only 8 bits wide, so LEN=256 ends on idx 8'hFF.
    localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

    state_e     state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] page_q, page_d;
    logic [7:0] dataLatch_q, dataLatch_d;
    logic       cycOdd_q;

    logic       trigger;

    assign trigger = cpu_we_i && (cpu_addr_i == REG_ADDR);

    // The CPU handshake depends only on the state register. A bus_rdy with
    // no input path cannot form a combinational loop through the CPU core.
    assign cpu_rdy_o    = (state_q == IDLE);
    assign dma_active_o = (state_q != IDLE);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            idx_q       <= 8'h00;
            page_q      <= 8'h00;
            dataLatch_q <= 8'h00;
            cycOdd_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            page_q      <= page_d;
            dataLatch_q <= dataLatch_d;
            cycOdd_q    <= ~cycOdd_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        page_d      = page_q;
        dataLatch_d = dataLatch_q;

        bus_addr_o  = cpu_addr_i;
        bus_dout_o  = 8'h00;
        bus_we_o    = 1'b0;

        unique case (state_q)
            IDLE: begin
                bus_dout_o = cpu_dout_i;
                bus_we_o   = cpu_we_i;
                if (trigger) begin
                    page_d  = cpu_dout_i;
                    idx_d   = 8'h00;
                    state_d = HALT;
                end
            end

            // HALT and ALIGN keep cpu_addr on the bus, but they block any
            // write. A CPU frozen on a write cycle then re-issues that write
            // after it resumes. The optional ALIGN cycle makes every READ
            // land on an even cycle.
            HALT: begin
                state_d = cycOdd_q ? READ : ALIGN;
            end

            ALIGN: begin
                state_d = READ;
            end

            READ: begin
                bus_addr_o  = {page_q, idx_q};
                dataLatch_d = bus_din_i;
                state_d     = WRITE;
            end

            WRITE: begin
                bus_addr_o = DST_ADDR;
                bus_dout_o = dataLatch_q;
                bus_we_o   = 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = 8'h00;
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 8'h01;
                    state_d = READ;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// ---------------------------------------------------------------------------
// tb_oam_dma_arbiter
//
// Testbench for oam_dma_arbiter. It instantiates two copies of the design:
// a full-size copy (LEN=256) attached to a 64 KiB RAM model, and a short
// copy (LEN=4) attached to a simple ROM function.
//
// Each time a transfer is started, the stimulus pushes the expected DMA
// writes and the expected stall length into queues. Separate monitors take
// entries from those queues when each DMA write appears on the bus, and when
// cpu_rdy comes back high.
// ---------------------------------------------------------------------------
module tb_oam_dma_arbiter;

    typedef struct packed {
        logic [15:0] rdAddr;
        logic [7:0]  data;
    } xfer_t;

    logic        clk = 1'b0;
    logic        reset;

    // Signals for the full-size DUT (LEN=256)
    logic [15:0] cpuAddr;
    logic [7:0]  cpuDout;
    logic        cpuWe;
    logic        cpuRdy;
    logic [15:0] busAddr;
    logic [7:0]  busDout;
    logic        busWe;
    logic [7:0]  busDin;
    logic        dmaActive;

    // Signals for the short DUT (LEN=4)
    logic [15:0] c4Addr;
    logic [7:0]  c4Dout;
    logic        c4We;
    logic        r4Rdy;
    logic [15:0] b4Addr;
    logic [7:0]  b4Dout;
    logic        b4We;
    logic [7:0]  b4Din;
    logic        dma4Active;

    logic [7:0]  mem [0:65535];
    logic        tbOdd;

    int          nVectors     = 0;
    int          nMiscompares = 0;

    xfer_t       wrQ[$];
    xfer_t       wr4Q[$];
    int          stallQ[$];
    int          stall4Q[$];

    always #5 clk = ~clk;

    oam_dma_arbiter dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .cpu_addr_i   (cpuAddr),
        .cpu_dout_i   (cpuDout),
        .cpu_we_i     (cpuWe),
        .cpu_rdy_o    (cpuRdy),
        .bus_addr_o   (busAddr),
        .bus_dout_o   (busDout),
        .bus_we_o     (busWe),
        .bus_din_i    (busDin),
        .dma_active_o (dmaActive)
    );

    oam_dma_arbiter #(.LEN(4)) dut4 (
        .clk_i        (clk),
        .reset_i      (reset),
        .cpu_addr_i   (c4Addr),
        .cpu_dout_i   (c4Dout),
        .cpu_we_i     (c4We),
        .cpu_rdy_o    (r4Rdy),
        .bus_addr_o   (b4Addr),
        .bus_dout_o   (b4Dout),
        .bus_we_o     (b4We),
        .bus_din_i    (b4Din),
        .dma_active_o (dma4Active)
    );

    // System RAM for the full-size DUT. Reads are asynchronous, and writes
    // take effect at the clock edge.
    assign busDin = mem[busAddr];

    always @(posedge clk) begin
        if (busWe) mem[busAddr] <= busDout;
    end

    // ROM for the short DUT. Each byte is its low address byte XOR 8'h3C.
    assign b4Din = b4Addr[7:0] ^ 8'h3C;

    // Reference phase of the free-running cycle parity.
    always @(posedge clk) begin
        if (reset) tbOdd <= 1'b0;
        else       tbOdd <= ~tbOdd;
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] dout,
                                 input logic we);
        @(posedge clk);
        #1;
        cpuAddr = addr;
        cpuDout = dout;
        cpuWe   = we;
    endtask

    // Starts a transfer on the full-size DUT. The trigger cycle has parity
    // 'want' (pass -1 for either parity). nWrites is the number of writes
    // expected to appear before the transfer ends or is aborted.
    task automatic triggerMain(input logic [7:0] page, input int want,
                               input int nWrites);
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (want < 0 || int'(tbOdd) == want) break;
            @(posedge clk);
            #1;
        end
        if (want >= 0) checkOutput("trigger_parity", 32'(tbOdd), 32'(want));
        stallQ.push_back(1 + int'(tbOdd) + 2 * nWrites);
        cpuAddr = 16'h4014;
        cpuDout = page;
        cpuWe   = 1'b1;
        @(negedge clk);
        checkOutput("trigger_pass_addr", 32'(busAddr), 32'h4014);
        checkOutput("trigger_pass_we", 32'(busWe), 32'h1);
        checkOutput("trigger_pass_dout", 32'(busDout), 32'(page));
        @(posedge clk);
        #1;
        cpuAddr = 16'h8000;
        cpuWe   = 1'b0;
    endtask

    task automatic waitMainIdle(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (cpuRdy) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput(name, 32'(done), 32'h1);
    endtask

    // Monitor for the full-size DUT
    logic [15:0] prevAddr;
    logic        prevOdd;
    int          stallCnt = 0;
    xfer_t       item;

    always @(negedge clk) begin
        checkOutput("rdy_xor_active", 32'(cpuRdy ^ dmaActive), 32'h1);
        if (dmaActive && !busWe) checkOutput("dma_dout_zero", 32'(busDout), 32'h0);
        if (dmaActive && busWe) begin
            if (wrQ.size() == 0) begin
                nVectors++;
                nMiscompares++;
                $display("[TB] FAIL unexpected_dma_write: got addr %h data %h, expected none",
                         busAddr, busDout);
            end else begin
                item = wrQ.pop_front();
                checkOutput("dma_rd_addr", 32'(prevAddr), 32'(item.rdAddr));
                checkOutput("read_parity", 32'(prevOdd), 32'h0);
                checkOutput("dma_wr_addr", 32'(busAddr), 32'h2004);
                checkOutput("dma_wr_data", 32'(busDout), 32'(item.data));
            end
        end
        if (!cpuRdy) begin
            stallCnt++;
        end else if (stallCnt > 0) begin
            if (stallQ.size() == 0) begin
                nVectors++;
                nMiscompares++;
                $display("[TB] FAIL unexpected_stall: got %0d cycles, expected none", stallCnt);
            end else begin
                checkOutput("stall_cycles", 32'(stallCnt), 32'(stallQ.pop_front()));
            end
            stallCnt = 0;
        end
        prevAddr = busAddr;
        prevOdd  = tbOdd;
    end

    // Monitor for the short DUT
    logic [15:0] prev4Addr;
    logic        prev4Odd;
    int          stall4Cnt = 0;
    xfer_t       item4;

    always @(negedge clk) begin
        checkOutput("rdy4_xor_active", 32'(r4Rdy ^ dma4Active), 32'h1);
        if (dma4Active && b4We) begin
            if (wr4Q.size() == 0) begin
                nVectors++;
                nMiscompares++;
                $display("[TB] FAIL unexpected_dma4_write: got addr %h data %h, expected none",
                         b4Addr, b4Dout);
            end else begin
                item4 = wr4Q.pop_front();
                checkOutput("dma4_rd_addr", 32'(prev4Addr), 32'(item4.rdAddr));
                checkOutput("read4_parity", 32'(prev4Odd), 32'h0);
                checkOutput("dma4_wr_addr", 32'(b4Addr), 32'h2004);
                checkOutput("dma4_wr_data", 32'(b4Dout), 32'(item4.data));
            end
        end
        if (!r4Rdy) begin
            stall4Cnt++;
        end else if (stall4Cnt > 0) begin
            if (stall4Q.size() == 0) begin
                nVectors++;
                nMiscompares++;
                $display("[TB] FAIL unexpected_stall4: got %0d cycles, expected none", stall4Cnt);
            end else begin
                checkOutput("stall4_cycles", 32'(stall4Cnt), 32'(stall4Q.pop_front()));
            end
            stall4Cnt = 0;
        end
        prev4Addr = b4Addr;
        prev4Odd  = tbOdd;
    end

    initial begin
        int  wrCount;
        bit  done;

        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
            mem[16'h0300 + i] = 8'(i * 7 + 1);
        end

        reset   = 1'b1;
        cpuAddr = 16'h0000;
        cpuDout = 8'h00;
        cpuWe   = 1'b0;
        c4Addr  = 16'h8000;
        c4Dout  = 8'h00;
        c4We    = 1'b0;

        // Reset held for 3 clocks, with the bus following the CPU inputs
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'h1000 + 16'(i), 8'h10 + 8'(i), i[0]);
            @(negedge clk);
            checkOutput("reset_rdy", 32'(cpuRdy), 32'h1);
            checkOutput("reset_active", 32'(dmaActive), 32'h0);
            checkOutput("reset_pass_addr", 32'(busAddr), 32'h1000 + 32'(i));
            checkOutput("reset_pass_we", 32'(busWe), 32'(i[0]));
        end
        @(posedge clk);
        #1;
        reset   = 1'b0;
        cpuAddr = 16'h8000;
        cpuWe   = 1'b0;

        // Reset and trigger in the same cycle: reset takes priority
        @(posedge clk);
        #1;
        reset   = 1'b1;
        cpuAddr = 16'h4014;
        cpuDout = 8'h02;
        cpuWe   = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        cpuAddr = 16'h8000;
        cpuWe   = 1'b0;
        @(negedge clk);
        checkOutput("reset_beats_trigger", 32'(cpuRdy), 32'h1);

        // Writes to nearby addresses and non-write accesses must not trigger
        applyStimulus(16'h4015, 8'h02, 1'b1);
        @(negedge clk);
        checkOutput("no_trig_4015_rdy", 32'(cpuRdy), 32'h1);
        applyStimulus(16'h4014, 8'h02, 1'b0);
        @(negedge clk);
        checkOutput("no_trig_read_rdy", 32'(cpuRdy), 32'h1);
        checkOutput("read_pass_we", 32'(busWe), 32'h0);
        checkOutput("read_pass_addr", 32'(busAddr), 32'h4014);
        applyStimulus(16'h8000, 8'h00, 1'b0);
        @(negedge clk);
        checkOutput("no_trig_after_rdy", 32'(cpuRdy), 32'h1);

        // Full 256-byte copy from page 02
        for (int i = 0; i < 256; i++) wrQ.push_back({16'h0200 + 16'(i), 8'(i) ^ 8'hA5});
        triggerMain(8'h02, -1, 256);
        waitMainIdle("xfer_p02_done");

        // Trigger parity controls whether ALIGN is inserted (514, then 513)
        for (int i = 0; i < 256; i++) wrQ.push_back({16'h0300 + 16'(i), 8'(i * 7 + 1)});
        triggerMain(8'h03, 1, 256);
        waitMainIdle("xfer_odd_done");
        for (int i = 0; i < 256; i++) wrQ.push_back({16'h0300 + 16'(i), 8'(i * 7 + 1)});
        triggerMain(8'h03, 0, 256);
        waitMainIdle("xfer_even_done");

        // Reset during the WRITE for idx 100 aborts the transfer
        for (int i = 0; i <= 100; i++) wrQ.push_back({16'h0200 + 16'(i), 8'(i) ^ 8'hA5});
        triggerMain(8'h02, -1, 101);
        wrCount = 0;
        done    = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (dmaActive && busWe) wrCount++;
            if (wrCount == 101) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput("abort_reached_idx100", 32'(done), 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_rdy", 32'(cpuRdy), 32'h1);
        checkOutput("abort_active", 32'(dmaActive), 32'h0);
        checkOutput("abort_we", 32'(busWe), 32'h0);
        repeat (20) @(negedge clk);

        // Short DUT: copy page FF and hold the trigger write across the stall,
        // so that it starts a second transfer on the first cycle after resume
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++)
                wr4Q.push_back({16'hFF00 + 16'(i), 8'(i) ^ 8'h3C});
        @(posedge clk);
        #1;
        stall4Q.push_back(9 + int'(tbOdd));
        c4Addr = 16'h4014;
        c4Dout = 8'hFF;
        c4We   = 1'b1;
        @(negedge clk);
        done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (r4Rdy) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput("xfer4_first_done", 32'(done), 32'h1);
        stall4Q.push_back(9 + int'(tbOdd));
        @(posedge clk);
        #1;
        c4We   = 1'b0;
        c4Addr = 16'h8000;
        done   = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (r4Rdy) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput("xfer4_second_done", 32'(done), 32'h1);

        repeat (5) @(negedge clk);
        checkOutput("wr_queue_drained", 32'(wrQ.size()), 32'h0);
        checkOutput("stall_queue_drained", 32'(stallQ.size()), 32'h0);
        checkOutput("wr4_queue_drained", 32'(wr4Q.size()), 32'h0);
        checkOutput("stall4_queue_drained", 32'(stall4Q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
